// File: rtl/imm_pkg.sv
// Shared constants for the immediate packer and the datapath extender.
// Holds the EOp encodings, the request modes and the packer FSM state type.
// Purely declarative; no logic of its own.
package imm_pkg;

  // Extender opcodes (must match the extender's decode)
  localparam logic [1:0] EOP_SEXT = 2'b00;  // sign-extend imm
  localparam logic [1:0] EOP_ZEXT = 2'b01;  // zero-extend imm
  localparam logic [1:0] EOP_LUI  = 2'b10;  // imm << 16
  localparam logic [1:0] EOP_SHL2 = 2'b11;  // sign-extend imm, then << 2

  // Request modes
  localparam logic [1:0] MODE_LI     = 2'b00;  // load constant
  localparam logic [1:0] MODE_LOGIC  = 2'b01;  // logical (zero-extended) operand
  localparam logic [1:0] MODE_BRANCH = 2'b10;  // branch byte offset
  localparam logic [1:0] MODE_RSVD   = 2'b11;  // reserved, always fails

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,  // no beat pending
    ST_BEAT1 = 2'b01,  // first (or only) beat presented
    ST_BEAT2 = 2'b10   // second beat of a lui/ori pair presented
  } state_t;

endpackage

// File: rtl/imm_classify.sv
// Classifies a 32-bit value/mode into the immediate + EOp that rebuild it.
// Purely combinational (zero latency).
// No handshake; the caller decides when results are captured.
module imm_classify
  import imm_pkg::*;
#(
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input  logic [31:0] i_value,
  input  logic [1:0]  i_mode,
  output logic [15:0] o_imm1,
  output logic [1:0]  o_eop1,
  output logic        o_split,
  output logic        o_fail,
  output logic [15:0] o_imm2
);

  logic w_s;  // fits a sign-extended 16-bit immediate
  logic w_z;  // fits a zero-extended 16-bit immediate
  logic w_l;  // low half is zero, a single lui reproduces it
  logic w_b;  // word-aligned and fits a sign-extended 16-bit word offset

  assign w_s = (&i_value[31:15]) | ~(|i_value[31:15]);
  assign w_z = ~(|i_value[31:16]);
  assign w_l = ~(|i_value[15:0]);
  assign w_b = ~(|i_value[1:0]) & ((&i_value[31:17]) | ~(|i_value[31:17]));

  // Pick the first encoding that reproduces the value; fail beats are all-zero.
  always_comb begin
    o_imm1  = 16'h0000;
    o_eop1  = EOP_SEXT;
    o_split = 1'b0;
    o_fail  = 1'b0;
    o_imm2  = i_value[15:0];
    case (i_mode)
      MODE_LI: begin
        if (w_s) begin
          o_imm1 = i_value[15:0];
          o_eop1 = EOP_SEXT;
        end else if (w_z) begin
          o_imm1 = i_value[15:0];
          o_eop1 = EOP_ZEXT;
        end else if (w_l) begin
          o_imm1 = i_value[31:16];
          o_eop1 = EOP_LUI;
        end else if (ALLOW_SPLIT) begin
          // lui of the high half now, ori of the low half on the next beat
          o_imm1  = i_value[31:16];
          o_eop1  = EOP_LUI;
          o_split = 1'b1;
        end else begin
          o_fail = 1'b1;
        end
      end
      MODE_LOGIC: begin
        if (w_z) begin
          o_imm1 = i_value[15:0];
          o_eop1 = EOP_ZEXT;
        end else begin
          o_fail = 1'b1;
        end
      end
      MODE_BRANCH: begin
        if (w_b) begin
          o_imm1 = i_value[17:2];
          o_eop1 = EOP_SHL2;
        end else begin
          o_fail = 1'b1;
        end
      end
      default: o_fail = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_pack.sv
// Immediate packer: value/mode in, one or two (imm, EOp) beats out.
// Latency: 1 cycle from input handshake to out_valid; one beat per cycle.
// Backpressure: out_ready=0 freezes state and outputs; in_ready only when a last beat leaves or idle.
module imm_pack
  import imm_pkg::*;
#(
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [1:0]  in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm,
  output logic [1:0]  out_eop,
  output logic        out_last,
  output logic        out_fail
);

  state_t      r_state;
  logic        r_out_valid;
  logic [15:0] r_imm;
  logic [1:0]  r_eop;
  logic        r_last;
  logic        r_fail;
  logic [15:0] r_lo;  // low half held for the second beat of a pair

  state_t      w_nxt_state;
  logic        w_nxt_valid;
  logic [15:0] w_nxt_imm;
  logic [1:0]  w_nxt_eop;
  logic        w_nxt_last;
  logic        w_nxt_fail;
  logic [15:0] w_nxt_lo;
  logic        w_load;

  logic        w_in_ready;
  logic        w_accept;
  logic [15:0] w_cls_imm1;
  logic [1:0]  w_cls_eop1;
  logic        w_cls_split;
  logic        w_cls_fail;
  logic [15:0] w_cls_imm2;

  imm_classify #(.ALLOW_SPLIT(ALLOW_SPLIT)) u_classify (
    .i_value (in_value),
    .i_mode  (in_mode),
    .o_imm1  (w_cls_imm1),
    .o_eop1  (w_cls_eop1),
    .o_split (w_cls_split),
    .o_fail  (w_cls_fail),
    .o_imm2  (w_cls_imm2)
  );

  // The only out_ready -> in_ready path: a departing last beat frees the slot.
  assign w_in_ready = (r_state == ST_IDLE) | (r_out_valid & r_last & out_ready);
  assign w_accept   = in_valid & w_in_ready;

  // Next-state and next-output selection; everything holds unless a beat retires.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_valid = r_out_valid;
    w_nxt_imm   = r_imm;
    w_nxt_eop   = r_eop;
    w_nxt_last  = r_last;
    w_nxt_fail  = r_fail;
    w_nxt_lo    = r_lo;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: w_load = w_accept;
      ST_BEAT1: begin
        if (out_ready) begin
          if (r_last) begin
            w_load = w_accept;
            if (!w_accept) begin
              w_nxt_state = ST_IDLE;
              w_nxt_valid = 1'b0;
            end
          end else begin
            w_nxt_state = ST_BEAT2;
            w_nxt_imm   = r_lo;
            w_nxt_eop   = EOP_ZEXT;
            w_nxt_last  = 1'b1;
            w_nxt_fail  = 1'b0;
          end
        end
      end
      ST_BEAT2: begin
        if (out_ready) begin
          w_load = w_accept;
          if (!w_accept) begin
            w_nxt_state = ST_IDLE;
            w_nxt_valid = 1'b0;
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_valid = 1'b0;
      end
    endcase
    if (w_load) begin
      w_nxt_state = ST_BEAT1;
      w_nxt_valid = 1'b1;
      w_nxt_imm   = w_cls_imm1;
      w_nxt_eop   = w_cls_eop1;
      w_nxt_last  = ~w_cls_split;
      w_nxt_fail  = w_cls_fail;
      w_nxt_lo    = w_cls_imm2;
    end
  end

  // State and output registers; reset wins over any simultaneous handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_imm       <= 16'h0000;
      r_eop       <= EOP_SEXT;
      r_last      <= 1'b0;
      r_fail      <= 1'b0;
      r_lo        <= 16'h0000;
    end else begin
      r_state     <= w_nxt_state;
      r_out_valid <= w_nxt_valid;
      r_imm       <= w_nxt_imm;
      r_eop       <= w_nxt_eop;
      r_last      <= w_nxt_last;
      r_fail      <= w_nxt_fail;
      r_lo        <= w_nxt_lo;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_imm   = r_imm;
  assign out_eop   = r_eop;
  assign out_last  = r_last;
  assign out_fail  = r_fail;

endmodule

// File: tb/tb_imm_pack.sv
// Directed table plus corner-case sequences and a random extend round-trip for imm_pack.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Exercises backpressure, split pairs, reset mid-pair and the no-split variant.
module tb_imm_pack;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, out_fail;
  logic [31:0] in_value;
  logic [1:0]  in_mode, out_eop;
  logic [15:0] out_imm;

  logic        ns_in_valid, ns_in_ready, ns_out_valid, ns_out_ready, ns_out_last, ns_out_fail;
  logic [31:0] ns_in_value;
  logic [1:0]  ns_in_mode, ns_out_eop;
  logic [15:0] ns_out_imm;

  int checks = 0;
  int errors = 0;

  imm_pack #(.ALLOW_SPLIT(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_eop(out_eop),
    .out_last(out_last), .out_fail(out_fail)
  );

  imm_pack #(.ALLOW_SPLIT(1'b0)) u_ns (
    .clk(clk), .reset(reset),
    .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_value(ns_in_value), .in_mode(ns_in_mode),
    .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_imm(ns_out_imm), .out_eop(ns_out_eop),
    .out_last(ns_out_last), .out_fail(ns_out_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] value;
    logic [15:0] imm;
    logic [1:0]  eop;
    logic        fail;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [15:0] imm, input logic [1:0] eop);
    case (eop)
      2'd0:    ext = {{16{imm[15]}}, imm};
      2'd1:    ext = {16'h0000, imm};
      2'd2:    ext = {imm, 16'h0000};
      default: ext = {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

  // Present one input and return at the falling edge after it was accepted.
  task automatic send(input logic [1:0] m, input logic [31:0] v);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = m;
    in_value = v;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Capture the presented beat (out_ready must be 1) and step past its handshake.
  task automatic get_beat(output logic [15:0] imm, output logic [1:0] eop,
                          output logic last, output logic fail, output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    ok   = out_valid;
    imm  = out_imm;
    eop  = out_eop;
    last = out_last;
    fail = out_fail;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] i1, i2;
    logic [1:0]  e1, e2;
    logic        l1, l2, f1, f2;
    bit          ok1, ok2;
    logic [31:0] v, recon, hw;
    logic [1:0]  m;
    logic        unrep;
    int          stray;

    vecs[0]  = '{2'd0, 32'hFFFF8000, 16'h8000, 2'd0, 1'b0};
    vecs[1]  = '{2'd0, 32'h0000ABCD, 16'hABCD, 2'd1, 1'b0};
    vecs[2]  = '{2'd0, 32'h12340000, 16'h1234, 2'd2, 1'b0};
    vecs[3]  = '{2'd0, 32'h00000000, 16'h0000, 2'd0, 1'b0};
    vecs[4]  = '{2'd0, 32'h00007FFF, 16'h7FFF, 2'd0, 1'b0};
    vecs[5]  = '{2'd0, 32'h00008000, 16'h8000, 2'd1, 1'b0};
    vecs[6]  = '{2'd2, 32'hFFFFFFFC, 16'hFFFF, 2'd3, 1'b0};
    vecs[7]  = '{2'd2, 32'h0001FFFC, 16'h7FFF, 2'd3, 1'b0};
    vecs[8]  = '{2'd2, 32'h00020000, 16'h0000, 2'd0, 1'b1};
    vecs[9]  = '{2'd2, 32'h00000002, 16'h0000, 2'd0, 1'b1};
    vecs[10] = '{2'd1, 32'h00010000, 16'h0000, 2'd0, 1'b1};
    vecs[11] = '{2'd1, 32'h0000FFFF, 16'hFFFF, 2'd1, 1'b0};
    vecs[12] = '{2'd3, 32'h00000000, 16'h0000, 2'd0, 1'b1};
    vecs[13] = '{2'd3, 32'hDEADBEEF, 16'h0000, 2'd0, 1'b1};

    reset = 1'b1;
    in_valid = 1'b0; in_value = '0; in_mode = '0; out_ready = 1'b1;
    ns_in_valid = 1'b0; ns_in_value = '0; ns_in_mode = '0; ns_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_imm", {16'd0, out_imm}, 32'd0);
    check("rst_out_eop", {30'd0, out_eop}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_fail", {31'd0, out_fail}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single-beat table; out_valid must be up the cycle after acceptance
    for (int k = 0; k < 14; k++) begin
      send(vecs[k].mode, vecs[k].value);
      check($sformatf("vec%0d_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_imm", k), {16'd0, out_imm}, {16'd0, vecs[k].imm});
      check($sformatf("vec%0d_eop", k), {30'd0, out_eop}, {30'd0, vecs[k].eop});
      check($sformatf("vec%0d_last", k), {31'd0, out_last}, 32'd1);
      check($sformatf("vec%0d_fail", k), {31'd0, out_fail}, {31'd0, vecs[k].fail});
      @(negedge clk);
    end

    // Back-to-back single beats under a ready consumer
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 2'd0; in_value = 32'h0000ABCD;
    @(negedge clk);
    check("b2b_in_ready1", {31'd0, in_ready}, 32'd1);
    check("b2b_beat1", {14'd0, out_eop, out_imm}, {14'd0, 2'd1, 16'hABCD});
    in_value = 32'h12340000;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_valid2", {31'd0, out_valid}, 32'd1);
    check("b2b_beat2", {14'd0, out_eop, out_imm}, {14'd0, 2'd2, 16'h1234});
    check("b2b_in_ready2", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Split pair held under backpressure, with a new input waiting
    out_ready = 1'b0;
    send(2'd0, 32'h12345678);
    in_valid = 1'b1; in_mode = 2'd0; in_value = 32'h0000ABCD;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("split_hold%0d", c), {out_valid, out_last, out_fail, 11'd0, out_eop, out_imm},
            {1'b1, 1'b0, 1'b0, 11'd0, 2'd2, 16'h1234});
      check($sformatf("split_in_ready%0d", c), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("split_b1_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("split_beat2", {out_valid, out_last, out_fail, 11'd0, out_eop, out_imm},
          {1'b1, 1'b1, 1'b0, 11'd0, 2'd1, 16'h5678});
    check("split_b2_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("split_next", {out_valid, 13'd0, out_eop, out_imm}, {1'b1, 13'd0, 2'd1, 16'hABCD});
    @(negedge clk);

    // Reset while beat 1 of a pair is presented, with a competing handshake
    out_ready = 1'b0;
    send(2'd0, 32'hDEAD0001);
    check("rstmid_beat1", {out_valid, out_last, 12'd0, out_eop, out_imm}, {1'b1, 1'b0, 12'd0, 2'd2, 16'hDEAD});
    reset = 1'b1;
    in_valid = 1'b1; in_value = 32'h0000ABCD;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    check("rstmid_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) stray++;
      @(negedge clk);
    end
    check("rstmid_no_stray", stray, 32'd0);

    // No-split variant reports an unrepresentable constant as a single fail beat
    ns_in_valid = 1'b1; ns_in_mode = 2'd0; ns_in_value = 32'h12345678;
    @(negedge clk);
    ns_in_valid = 1'b0;
    check("nosplit_beat", {ns_out_valid, ns_out_last, ns_out_fail, 11'd0, ns_out_eop, ns_out_imm},
          {1'b1, 1'b1, 1'b1, 11'd0, 2'd0, 16'h0000});
    @(negedge clk);
    check("nosplit_single", {31'd0, ns_out_valid}, 32'd0);

    // Random round trip through the extender
    out_ready = 1'b1;
    for (int r = 0; r < 1000; r++) begin
      hw = $urandom;
      case ($urandom_range(0, 4))
        0: v = $urandom;
        1: v = {{16{hw[15]}}, hw[15:0]};
        2: v = {16'h0000, hw[15:0]};
        3: v = {hw[15:0], 16'h0000};
        default: v = {{14{hw[15]}}, hw[15:0], 2'b00} ^ {30'd0, hw[17:16]};
      endcase
      m = 2'($urandom_range(0, 3));
      send(m, v);
      get_beat(i1, e1, l1, f1, ok1);
      i2 = 16'h0; e2 = 2'd0; l2 = 1'b1; f2 = 1'b0; ok2 = 1'b1;
      if (ok1 && !l1) get_beat(i2, e2, l2, f2, ok2);
      unrep = (m == 2'd3) || (m == 2'd1 && v[31:16] != 16'h0) ||
              (m == 2'd2 && ext(v[17:2], 2'd3) != v);
      if (!ok1 || !ok2) begin
        check($sformatf("rnd%0d_beat_timeout", r), 32'd0, 32'd1);
      end else if (unrep) begin
        check($sformatf("rnd%0d_fail_m%0d_v%08h", r, m, v), {31'd0, f1}, 32'd1);
      end else begin
        recon = ext(i1, e1);
        if (!l1) recon = recon | ext(i2, e2);
        check($sformatf("rnd%0d_roundtrip_m%0d_f%0d_l%0d", r, m, f1, l2), recon, v);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
